// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Imported by the picker and the top.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

  // ID width that stays at least one bit for degenerate counts
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Wraps modulo N, so non-power-of-2 request counts are handled.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_o,
  output logic          any_o
);

  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    gnt_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N)
        idx = idx - N;
      sel = IW'(idx);
      if (!any_o && req_i[sel]) begin
        any_o = 1'b1;
        gnt_o = sel;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst lock in front of a FIFO.
// Grant is combinational; state only tracks lock owner and rotation.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4,
  localparam int ID_W      = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          grant_vld
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] x);
    return (x == LAST_ID) ? '0 : x + ID_W'(1);
  endfunction

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [ID_W-1:0] rr_q, rr_d;

  logic            hold;
  logic            rel;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] pick;
  logic            any;
  logic [ID_W-1:0] g;
  logic            xfer;

  assign hold = (state_q == LOCK) && req_valid[owner_q];
  assign rel  = (state_q == LOCK) && !req_valid[owner_q];
  // A released lock rotates past the owner in the same cycle
  assign ptr  = rel ? nxt(owner_q) : rr_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr),
    .gnt_o (pick),
    .any_o (any)
  );

  assign g         = hold ? owner_q : pick;
  assign grant_vld = rst_n && any;
  assign grant_id  = g;
  assign xfer      = grant_vld && !fifo_full;
  assign fifo_w_en = xfer;

  always_comb begin
    fifo_data_in = '0;
    req_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == ID_W'(i)) begin
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = xfer;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    if (xfer) begin
      if (hold) begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          rr_d    = nxt(owner_q);
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end else if (BURST_LEN > 1) begin
        state_d = LOCK;
        owner_d = g;
        beat_d  = BW'(1);
      end else begin
        state_d = IDLE;
        rr_d    = nxt(g);
        beat_d  = '0;
      end
    end else if (rel && !fifo_full) begin
      state_d = IDLE;
      rr_d    = nxt(owner_q);
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      beat_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural FIFO.
// Second instance with BURST_LEN=1 covers pure round-robin.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready, rr_ready;
  logic          fifo_w_en, rr_wen;
  logic [DW-1:0] fifo_data_in, rr_data;
  logic          fifo_full;
  logic [1:0]    gid, rr_gid;
  logic          gvld, rr_gvld;

  logic [7:0]    pq [NR][$];
  logic [7:0]    sb[$];
  logic [7:0]    rd_exp[$];
  logic [7:0]    fifo_q[$];
  logic [NR-1:0] en;
  logic [NR-1:0] rdy_s;
  bit            force_full;
  bit            rd_req;
  int            depth;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .BURST_LEN  (4)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .grant_id     (gid),
    .grant_vld    (gvld)
  );

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .BURST_LEN  (1)
  ) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (rr_ready),
    .fifo_w_en    (rr_wen),
    .fifo_data_in (rr_data),
    .fifo_full    (fifo_full),
    .grant_id     (rr_gid),
    .grant_vld    (rr_gvld)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tag8(input int i, input int k);
    logic [31:0] a, b;
    a = i;
    b = k;
    return {a[1:0], b[5:0]};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
    fifo_full = force_full || (fifo_q.size() >= depth);
  endtask

  task automatic mon();
    logic [31:0] e;
    rdy_s = req_ready;
    chk("one_rdy", $countones(req_ready), {31'd0, fifo_w_en});
    if (fifo_w_en) begin
      chk("wr_full", {31'd0, fifo_full}, 32'd0);
      chk("rdy_gnt", {31'd0, req_ready[gid]}, 32'd1);
      chk("tag_gnt", {30'd0, fifo_data_in[7:6]}, {30'd0, gid});
      if (sb.size() > 0) e = {24'd0, sb.pop_front()};
      else e = 32'hDEAD;
      chk("wdata", {24'd0, fifo_data_in}, e);
      fifo_q.push_back(fifo_data_in);
    end
  endtask

  task automatic edge_drive();
    logic [31:0] e;
    logic [7:0]  d;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (rdy_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    rdy_s = '0;
    if (rd_req && fifo_q.size() > 0) begin
      d = fifo_q.pop_front();
      if (rd_exp.size() > 0) e = {24'd0, rd_exp.pop_front()};
      else e = 32'hDEAD;
      chk("rdback", {24'd0, d}, e);
    end
    drive();
  endtask

  task automatic cyc();
    edge_drive();
    @(negedge clk);
    mon();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) pq[i].delete();
    sb.delete();
    rd_exp.delete();
    fifo_q.delete();
    en = '1;
    rdy_s = '0;
    force_full = 0;
    rd_req = 0;
    depth = 64;
    drive();
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) pq[i].push_back(tag8(i, k));
  endtask

  task automatic exp_w(input int i, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      sb.push_back(tag8(i, k));
      rd_exp.push_back(tag8(i, k));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    mon();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    clear_all();

    // reset with everyone requesting
    for (int i = 0; i < NR; i++) load(i, 1);
    exp_w(0, 0, 0);
    rst_n = 1'b0;
    drive();
    cyc();
    chk("rst_wen", {31'd0, fifo_w_en}, 32'd0);
    chk("rst_rdy", {28'd0, req_ready}, 32'd0);
    chk("rst_gvld", {31'd0, gvld}, 32'd0);
    chk("rst_rr_wen", {31'd0, rr_wen}, 32'd0);
    chk("rst_rr_rdy", {28'd0, rr_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    mon();
    chk("rel_gid", {30'd0, gid}, 32'd0);
    chk("rel_gvld", {31'd0, gvld}, 32'd1);
    chk("rel_rr_gid", {30'd0, rr_gid}, 32'd0);
    chk("t1_left", sb.size(), 32'd0);

    // all four valid: rr instance rotates, burst instance locks
    clear_all();
    for (int i = 0; i < NR; i++) load(i, 8);
    exp_w(0, 0, 3);
    exp_w(1, 0, 3);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      chk("rr_gid", {30'd0, rr_gid}, k % 4);
      chk("rr_wen", {31'd0, rr_wen}, 32'd1);
      chk("rr_rdy", {28'd0, rr_ready}, 32'd1 << (k % 4));
    end
    chk("t2_left", sb.size(), 32'd0);

    // req0 and req2 alternate in bursts of four
    clear_all();
    load(0, 8);
    load(2, 8);
    exp_w(0, 0, 3);
    exp_w(2, 0, 3);
    exp_w(0, 4, 4);
    do_reset();
    repeat (8) cyc();
    chk("t3_left", sb.size(), 32'd0);

    // stall mid-burst keeps owner and remaining beats
    clear_all();
    load(1, 6);
    load(3, 2);
    exp_w(1, 0, 3);
    exp_w(3, 0, 1);
    exp_w(1, 4, 4);
    do_reset();
    cyc();
    force_full = 1;
    repeat (3) begin
      cyc();
      chk("stall_wen", {31'd0, fifo_w_en}, 32'd0);
      chk("stall_rdy", {28'd0, req_ready}, 32'd0);
      chk("stall_gid", {30'd0, gid}, 32'd1);
      chk("stall_gvld", {31'd0, gvld}, 32'd1);
    end
    force_full = 0;
    repeat (5) cyc();
    chk("t4_left", sb.size(), 32'd0);

    // owner drops valid: lock released in the same cycle
    clear_all();
    load(0, 3);
    load(3, 2);
    exp_w(0, 0, 0);
    exp_w(3, 0, 1);
    exp_w(0, 1, 1);
    do_reset();
    en[0] = 1'b0;
    cyc();
    chk("drop_gid", {30'd0, gid}, 32'd3);
    chk("drop_wen", {31'd0, fifo_w_en}, 32'd1);
    cyc();
    cyc();
    chk("drop_idle", {31'd0, gvld}, 32'd0);
    en[0] = 1'b1;
    cyc();
    chk("t5_left", sb.size(), 32'd0);

    // reset pulse mid-burst
    clear_all();
    load(2, 6);
    load(0, 2);
    en[0] = 1'b0;
    exp_w(2, 0, 1);
    exp_w(0, 0, 1);
    exp_w(2, 2, 2);
    do_reset();
    cyc();
    edge_drive();
    #1;
    chk("pre_rst_wen", {31'd0, fifo_w_en}, 32'd1);
    chk("pre_rst_gid", {30'd0, gid}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", {31'd0, fifo_w_en}, 32'd0);
    chk("mid_rst_rdy", {28'd0, req_ready}, 32'd0);
    en[0] = 1'b1;
    drive();
    @(negedge clk);
    mon();
    cyc();
    rst_n = 1'b1;
    #1;
    mon();
    chk("post_rst_gid", {30'd0, gid}, 32'd0);
    cyc();
    cyc();
    chk("t6_left", sb.size(), 32'd0);

    // depth-8 FIFO: ninth write waits for a read
    clear_all();
    depth = 8;
    for (int i = 0; i < 3; i++) load(i, 4);
    exp_w(0, 0, 3);
    exp_w(1, 0, 3);
    exp_w(2, 0, 3);
    do_reset();
    repeat (7) cyc();
    repeat (3) begin
      cyc();
      chk("full_wen", {31'd0, fifo_w_en}, 32'd0);
      chk("full_gid", {30'd0, gid}, 32'd2);
      chk("full_cnt", fifo_q.size(), 32'd8);
    end
    rd_req = 1;
    for (int g = 0; g < 20 && sb.size() > 0; g++) cyc();
    chk("t7_left", sb.size(), 32'd0);
    for (int g = 0; g < 40 && fifo_q.size() > 0; g++) cyc();
    chk("t7_drain", fifo_q.size(), 32'd0);
    chk("t7_rdexp", rd_exp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
